sort_checker: RTL and testbench
===============================

SORT_CHECKER -- requirements
Module: sort_checker

Interface
REQ-001 SHALL have parameter ADDR_WDTH, default 4, memory word-address width.
REQ-002 SHALL have parameter DATA_WDTH, default 32, element width.
REQ-003 SHALL have parameter RESP_WDTH, default 1, read-response width.
REQ-004 SHALL have clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have start  input  1  begin check when idle.
REQ-007 SHALL have arr_size  input  ADDR_WDTH+1  element count, sampled at accepted start.
REQ-008 SHALL have done  output  1  check finished; results valid.
REQ-009 SHALL have sorted  output  1  array is non-decreasing.
REQ-010 SHALL have err  output  1  bad size or error read response.
REQ-011 SHALL have fault_index  output  ADDR_WDTH  index of first out-of-order element.
REQ-012 SHALL have ar_valid / ar_ready / ar_address  out / in / out  1 / 1 / ADDR_WDTH  read-address channel.
REQ-013 SHALL have r_valid / r_ready / r_data / r_resp  in / out / in / in  1 / 1 / DATA_WDTH / RESP_WDTH  read-data channel.

Function
REQ-014 SHALL implement FSM IDLE, REQ, RESP, CMP, DONE.
REQ-015 IDLE: start=1 SHALL latch arr_size, clear done/sorted/err/fault_index, set idx=0; go REQ if 2<=size<=2^ADDR_WDTH, else DONE.
REQ-016 size 0 or 1 SHALL give DONE with sorted=1, err=0, no read issued.
REQ-017 size >2^ADDR_WDTH SHALL give DONE with err=1, sorted=0, no read issued.
REQ-018 REQ: ar_valid=1, ar_address=idx, held stable until ar_valid&ar_ready; then RESP.
REQ-019 RESP: r_ready=1 only in this state; on r_valid&r_ready capture r_data, go CMP; r_ready=0 in all other states.
REQ-020 At most one read outstanding; r_valid during REQ SHALL be left unaccepted.
REQ-021 r_resp!=0 on accepted beat SHALL set err=1, sorted=0, go DONE immediately.
REQ-022 CMP idx=0: store element as prev, idx+1, go REQ.
REQ-023 CMP idx>0: element<prev (unsigned, full DATA_WDTH) SHALL set sorted=0, fault_index=idx, go DONE; else prev=element.
REQ-024 CMP at idx=size-1 with no violation SHALL set sorted=1, go DONE; else idx+1, go REQ.
REQ-025 idx SHALL be ADDR_WDTH+1 bits; size=2^ADDR_WDTH reads addresses 0..2^ADDR_WDTH-1 without address wrap.
REQ-026 Per-element latency SHALL be 3 cycles minimum (REQ, RESP, CMP) with zero-wait memory.
REQ-027 DONE: done=1 held with stable results until start=1, which SHALL restart as from IDLE in that cycle.
REQ-028 start while in REQ/RESP/CMP SHALL be ignored.

Reset
REQ-029 rst_n=0 SHALL force IDLE at once from any state, including mid-transaction.
REQ-030 Reset values: done=0, sorted=0, err=0, fault_index=0, ar_valid=0, ar_address=0, r_ready=0.

Configuration
REQ-031 With CHECKER_SIGNED_CMP_EN defined, REQ-023 comparison SHALL be two's-complement signed.
REQ-032 Without CHECKER_SIGNED_CMP_EN, comparison SHALL be unsigned.

Verification
REQ-033 memory {1,2,2,7,9}, size=5, start -> 5 reads addr 0..4, done=1, sorted=1, err=0.
REQ-034 memory {3,5,4,8}, size=4 -> reads stop after addr 2, done=1, sorted=0, fault_index=2.
REQ-035 size=17 -> no ar_valid ever, done=1, err=1; size=1 -> done=1, sorted=1, no read.
REQ-036 always_error memory, size=4 -> first beat r_resp=1, done=1, err=1, one read only.
REQ-037 ar_ready delayed 3 cycles -> ar_address/ar_valid stable; rst_n=0 during RESP -> all outputs 0, IDLE next.
REQ-038 {0xFFFFFFFF,0x00000001}, size=2 -> unsigned: sorted=0, fault_index=1; CHECKER_SIGNED_CMP_EN: sorted=1.

Source files
------------

// File: rtl/sort_checker.sv
// sort_checker: walks an array held in an external memory through a simple
// valid/ready read-address / read-data channel pair and reports whether the
// elements are non-decreasing.
//
// Optional build macro:
//   CHECKER_SIGNED_CMP_EN  - when defined, elements are compared as two's
//                            complement signed values; otherwise unsigned.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   start             begin a check (accepted in IDLE or DONE only)
//   arr_size          element count, sampled when start is accepted
//   done              check finished, results below are valid and stable
//   sorted            array is non-decreasing
//   err               illegal size or error read response seen
//   fault_index       index of the first element smaller than its predecessor
//   ar_valid/ar_ready/ar_address        read-address channel
//   r_valid/r_ready/r_data/r_resp       read-data channel
module sort_checker #(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  output logic                 done,
  output logic                 sorted,
  output logic                 err,
  output logic [ADDR_WDTH-1:0] fault_index,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_RESP = 3'd2,
    ST_CMP  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_WDTH:0] SIZE_ZERO = {(ADDR_WDTH+1){1'b0}};
  localparam logic [ADDR_WDTH:0] SIZE_ONE  = {{ADDR_WDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WDTH:0] SIZE_TWO  = SIZE_ONE + SIZE_ONE;
  // Largest legal size is 2^ADDR_WDTH, which is why idx/size carry one extra bit.
  localparam logic [ADDR_WDTH:0] SIZE_MAX  = SIZE_ONE << ADDR_WDTH;

  // Element ordering test: true when a sorts strictly before b.
  function automatic logic elem_less(input logic [DATA_WDTH-1:0] a,
                                     input logic [DATA_WDTH-1:0] b);
`ifdef CHECKER_SIGNED_CMP_EN
    elem_less = ($signed(a) < $signed(b));
`else
    elem_less = (a < b);
`endif
  endfunction

  state_t                 state_r, state_nxt_s;
  logic [ADDR_WDTH:0]     idx_r, idx_nxt_s;
  logic [ADDR_WDTH:0]     size_r, size_nxt_s;
  logic [DATA_WDTH-1:0]   prev_r, prev_nxt_s;
  logic [DATA_WDTH-1:0]   elem_r, elem_nxt_s;
  logic                   done_r, done_nxt_s;
  logic                   sorted_r, sorted_nxt_s;
  logic                   err_r, err_nxt_s;
  logic [ADDR_WDTH-1:0]   fault_r, fault_nxt_s;
  logic                   ar_valid_r, ar_valid_nxt_s;
  logic [ADDR_WDTH-1:0]   ar_addr_r, ar_addr_nxt_s;
  logic                   r_ready_r, r_ready_nxt_s;

  logic size_in_range_s;
  logic size_small_s;
  logic ar_fire_s;
  logic r_fire_s;
  logic resp_bad_s;
  logic first_s;
  logic last_s;
  logic out_of_order_s;

  assign size_in_range_s = (arr_size >= SIZE_TWO) && (arr_size <= SIZE_MAX);
  assign size_small_s    = (arr_size < SIZE_TWO);
  assign ar_fire_s       = ar_valid_r & ar_ready;
  assign r_fire_s        = r_valid & r_ready_r;
  assign resp_bad_s      = (r_resp != {RESP_WDTH{1'b0}});
  assign first_s         = (idx_r == SIZE_ZERO);
  assign last_s          = (idx_r == (size_r - SIZE_ONE));
  assign out_of_order_s  = elem_less(elem_r, prev_r);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; DONE accepts start exactly like IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_nxt_s = size_in_range_s ? ST_REQ : ST_DONE;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_REQ: begin
        if (ar_fire_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_RESP: begin
        if (r_fire_s) begin
          state_nxt_s = resp_bad_s ? ST_DONE : ST_CMP;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      ST_CMP: begin
        if (first_s) begin
          state_nxt_s = ST_REQ;
        end else if (out_of_order_s || last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and result next values.
  always_comb begin
    idx_nxt_s    = idx_r;
    size_nxt_s   = size_r;
    prev_nxt_s   = prev_r;
    elem_nxt_s   = elem_r;
    done_nxt_s   = done_r;
    sorted_nxt_s = sorted_r;
    err_nxt_s    = err_r;
    fault_nxt_s  = fault_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          size_nxt_s   = arr_size;
          idx_nxt_s    = SIZE_ZERO;
          fault_nxt_s  = {ADDR_WDTH{1'b0}};
          // Trivial and illegal sizes finish without touching memory.
          done_nxt_s   = !size_in_range_s;
          sorted_nxt_s = size_small_s;
          err_nxt_s    = !size_in_range_s && !size_small_s;
        end else begin
          done_nxt_s = done_r;
        end
      end
      ST_RESP: begin
        if (r_fire_s) begin
          elem_nxt_s = r_data;
          if (resp_bad_s) begin
            err_nxt_s    = 1'b1;
            sorted_nxt_s = 1'b0;
            done_nxt_s   = 1'b1;
          end else begin
            err_nxt_s = err_r;
          end
        end else begin
          elem_nxt_s = elem_r;
        end
      end
      ST_CMP: begin
        if (first_s) begin
          prev_nxt_s = elem_r;
          idx_nxt_s  = idx_r + SIZE_ONE;
        end else if (out_of_order_s) begin
          sorted_nxt_s = 1'b0;
          fault_nxt_s  = idx_r[ADDR_WDTH-1:0];
          done_nxt_s   = 1'b1;
        end else begin
          prev_nxt_s = elem_r;
          if (last_s) begin
            sorted_nxt_s = 1'b1;
            done_nxt_s   = 1'b1;
          end else begin
            idx_nxt_s = idx_r + SIZE_ONE;
          end
        end
      end
      default: idx_nxt_s = idx_r;
    endcase
  end

  // Channel outputs decoded from the upcoming state so they can be registered
  // and still line up with the state they belong to.
  always_comb begin
    ar_valid_nxt_s = (state_nxt_s == ST_REQ);
    r_ready_nxt_s  = (state_nxt_s == ST_RESP);
    // idx never exceeds 2^ADDR_WDTH-1 while a read is pending, so the low bits are exact.
    ar_addr_nxt_s  = idx_nxt_s[ADDR_WDTH-1:0];
  end

  // Datapath, result and channel output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r      <= SIZE_ZERO;
      size_r     <= SIZE_ZERO;
      prev_r     <= {DATA_WDTH{1'b0}};
      elem_r     <= {DATA_WDTH{1'b0}};
      done_r     <= 1'b0;
      sorted_r   <= 1'b0;
      err_r      <= 1'b0;
      fault_r    <= {ADDR_WDTH{1'b0}};
      ar_valid_r <= 1'b0;
      ar_addr_r  <= {ADDR_WDTH{1'b0}};
      r_ready_r  <= 1'b0;
    end else begin
      idx_r      <= idx_nxt_s;
      size_r     <= size_nxt_s;
      prev_r     <= prev_nxt_s;
      elem_r     <= elem_nxt_s;
      done_r     <= done_nxt_s;
      sorted_r   <= sorted_nxt_s;
      err_r      <= err_nxt_s;
      fault_r    <= fault_nxt_s;
      ar_valid_r <= ar_valid_nxt_s;
      ar_addr_r  <= ar_addr_nxt_s;
      r_ready_r  <= r_ready_nxt_s;
    end
  end

  assign done        = done_r;
  assign sorted      = sorted_r;
  assign err         = err_r;
  assign fault_index = fault_r;
  assign ar_valid    = ar_valid_r;
  assign ar_address  = ar_addr_r;
  assign r_ready     = r_ready_r;

endmodule

// File: tb/tb_sort_checker.sv
// Testbench for sort_checker: a behavioural memory responder with adjustable
// latencies plus an array-scan reference model of the expected result.
module tb_sort_checker;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int RW = 1;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [AW:0]   arr_size;
  logic          done;
  logic          sorted;
  logic          err;
  logic [AW-1:0] fault_index;
  logic          ar_valid;
  logic          ar_ready;
  logic [AW-1:0] ar_address;
  logic          r_valid;
  logic          r_ready;
  logic [DW-1:0] r_data;
  logic [RW-1:0] r_resp;

  sort_checker #(.ADDR_WDTH(AW), .DATA_WDTH(DW), .RESP_WDTH(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .arr_size(arr_size),
    .done(done), .sorted(sorted), .err(err), .fault_index(fault_index),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_address(ar_address),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_resp(r_resp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // memory contents and responder knobs (written by the main sequence only)
  logic [DW-1:0] mem  [0:15];
  logic          errf [0:15];
  int            ar_delay;   // -1 = random 0..3
  int            r_delay;    // -1 = random 0..3
  bit            noise_en;   // stray r_valid beats when nothing is pending

  // responder-owned state
  logic [AW-1:0] addr_q [$];
  int            proto_err;
  bit            pend, ar_hs, r_hs, arw_prev;
  logic [AW-1:0] pend_addr, haddr, arw_addr;
  int            ar_wait, r_cnt;

  int pass_cnt, fail_cnt, total_cnt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory responder: decides channel inputs on the falling edge; a handshake
  // decided here takes effect on the following rising edge.
  initial begin
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_resp = '0;
    pend = 1'b0; ar_hs = 1'b0; r_hs = 1'b0; arw_prev = 1'b0;
    pend_addr = '0; haddr = '0; arw_addr = '0;
    ar_wait = -1; r_cnt = 0; proto_err = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0; ar_hs = 1'b0; r_hs = 1'b0; arw_prev = 1'b0;
        ar_wait = -1; r_cnt = 0; ar_ready = 1'b0; r_valid = 1'b0;
      end else begin
        if (ar_hs) begin
          pend = 1'b1; pend_addr = haddr; ar_hs = 1'b0;
          r_cnt = (r_delay < 0) ? int'($urandom_range(0, 3)) : r_delay;
        end
        if (r_hs) begin
          pend = 1'b0; r_hs = 1'b0;
        end
        // an address left waiting must stay asserted and unchanged
        if (arw_prev && (!ar_valid || ar_address !== arw_addr)) proto_err++;
        ar_ready = 1'b0;
        if (ar_valid && !pend) begin
          if (ar_wait < 0) ar_wait = (ar_delay < 0) ? int'($urandom_range(0, 3)) : ar_delay;
          if (ar_wait == 0) begin
            ar_ready = 1'b1; ar_hs = 1'b1; haddr = ar_address;
            addr_q.push_back(ar_address);
            ar_wait = -1;
          end else begin
            ar_wait--;
          end
        end
        if (ar_valid && pend) proto_err++;   // second outstanding read
        arw_prev = ar_valid && !ar_ready;
        arw_addr = ar_address;
        if (pend) begin
          if (r_cnt > 0) begin
            r_valid = 1'b0; r_cnt--;
          end else begin
            r_valid = 1'b1; r_data = mem[pend_addr]; r_resp = RW'(errf[pend_addr]);
            if (r_ready) r_hs = 1'b1;
          end
        end else if (noise_en && ($urandom_range(0, 1) == 1)) begin
          r_valid = 1'b1; r_data = $urandom; r_resp = '0;
        end else begin
          r_valid = 1'b0;
        end
        if (r_valid && r_ready && !pend) proto_err++;
      end
    end
  end

  function automatic bit ref_less(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef CHECKER_SIGNED_CMP_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Reference: scan the array as the reads would go, stopping at the first
  // error response or the first element smaller than its predecessor.
  function automatic void model(input int size, output bit e_sorted, output bit e_err,
                                output int e_fault, output int e_reads);
    e_sorted = 1'b0; e_err = 1'b0; e_fault = 0; e_reads = 0;
    if (size < 2) e_sorted = 1'b1;
    else if (size > 16) e_err = 1'b1;
    else begin
      for (int i = 0; i < size; i++) begin
        e_reads = i + 1;
        if (errf[i]) begin e_err = 1'b1; break; end
        if (i > 0 && ref_less(mem[i], mem[i-1])) begin e_fault = i; break; end
        if (i == size - 1) e_sorted = 1'b1;
      end
    end
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin mem[i] = '0; errf[i] = 1'b0; end
  endtask

  task automatic run_case(input string name, input int size, input int exp_lat, input bit busy_start);
    bit e_sorted, e_err;
    int e_fault, e_reads, base, cnt, n, mism;
    model(size, e_sorted, e_err, e_fault, e_reads);
    base = addr_q.size();
    @(negedge clk); start = 1'b1; arr_size = size[AW:0];
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!done && cnt < 3000) begin
      if (busy_start && cnt >= 1 && cnt < 4) begin start = 1'b1; arr_size = 5'd1; end
      else start = 1'b0;
      @(negedge clk); cnt++;
    end
    start = 1'b0;
    check({name, " done"}, 64'(done), 64'd1);
    check({name, " sorted"}, 64'(sorted), 64'(e_sorted));
    check({name, " err"}, 64'(err), 64'(e_err));
    check({name, " fault_index"}, 64'(fault_index), 64'(e_fault));
    n = addr_q.size() - base;
    check({name, " reads"}, 64'(n), 64'(e_reads));
    mism = 0;
    for (int k = 0; k < n; k++) if (addr_q[base+k] !== k[AW-1:0]) mism++;
    check({name, " addr_seq"}, 64'(mism), 64'd0);
    if (exp_lat >= 0) check({name, " latency"}, 64'(cnt), 64'(exp_lat));
    repeat (3) @(negedge clk);
    check({name, " hold"}, 64'({done, sorted, err, fault_index}),
          64'({1'b1, e_sorted, e_err, e_fault[AW-1:0]}));
  endtask

  initial begin
    int cnt, sz, base_v;
    pass_cnt = 0; fail_cnt = 0; total_cnt = 0;
    rst_n = 1'b0; start = 1'b0; arr_size = '0;
    ar_delay = 0; r_delay = 0; noise_en = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    #1;
    check("rst done", 64'(done), 64'd0);
    check("rst sorted", 64'(sorted), 64'd0);
    check("rst err", 64'(err), 64'd0);
    check("rst fault_index", 64'(fault_index), 64'd0);
    check("rst ar_valid", 64'(ar_valid), 64'd0);
    check("rst ar_address", 64'(ar_address), 64'd0);
    check("rst r_ready", 64'(r_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;

    // sorted with duplicates, zero-wait memory: 3 cycles per element
    clear_mem();
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd2; mem[3] = 32'd7; mem[4] = 32'd9;
    run_case("sorted5", 5, 15, 1'b0);

    // first violation at index 2
    clear_mem();
    mem[0] = 32'd3; mem[1] = 32'd5; mem[2] = 32'd4; mem[3] = 32'd8;
    run_case("viol4", 4, -1, 1'b0);

    run_case("size17", 17, -1, 1'b0);
    run_case("size1", 1, -1, 1'b0);
    run_case("size0", 0, -1, 1'b0);

    // every read answers with an error response
    clear_mem();
    for (int i = 0; i < 16; i++) errf[i] = 1'b1;
    run_case("allerr", 4, -1, 1'b0);

    // slow address acceptance, full-size array, start pulses while busy
    clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'(i * 3);
    ar_delay = 3;
    run_case("ardly16", 16, -1, 1'b1);
    ar_delay = 0;

    // sign boundary pair
    clear_mem();
    mem[0] = 32'hFFFF_FFFF; mem[1] = 32'h0000_0001;
    run_case("signpair", 2, -1, 1'b0);

    // reset while waiting on read data
    clear_mem();
    mem[0] = 32'd1; mem[1] = 32'd2; mem[2] = 32'd3; mem[3] = 32'd4;
    r_delay = 6;
    @(negedge clk); start = 1'b1; arr_size = 5'd4;
    @(negedge clk); start = 1'b0;
    cnt = 0;
    while (!r_ready && cnt < 50) begin @(negedge clk); cnt++; end
    check("rstresp reached", 64'(r_ready), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rstresp outputs", 64'({done, sorted, err, fault_index, ar_valid, ar_address, r_ready}), 64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    @(negedge clk);
    check("rstresp idle", 64'({done, ar_valid, r_ready}), 64'd0);
    r_delay = 0;

    // randomized arrays, sizes, latencies and error responses
    ar_delay = -1; r_delay = -1; noise_en = 1'b1;
    for (int t = 0; t < 24; t++) begin
      clear_mem();
      sz = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 19)) : int'($urandom_range(2, 16));
      base_v = int'($urandom);
      for (int i = 0; i < 16; i++) begin
        mem[i] = 32'(base_v);
        base_v = base_v + int'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 1) == 1) mem[$urandom_range(0, 15)] = $urandom;
      if ($urandom_range(0, 3) == 0) errf[$urandom_range(0, 15)] = 1'b1;
      run_case($sformatf("rand%0d", t), sz, -1, 1'b0);
    end

    check("protocol", 64'(proto_err), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
